shift_reg_sequencer: RTL and testbench

Controller that shares one WIDTH-bit parallel-load shift register between two requesters and sequences it through load-then-serialize transactions. Each requester presents a parallel word over a valid/ready handshake. A round-robin arbiter grants one requester, loads its word into the register, and shifts the word out MSB-first under consumer backpressure. It sits between the parallel-word producers and a single serial sink.

---
 rtl/shift_reg_seq_pkg.sv | 13 +
 rtl/shift_reg_core.sv | 35 +++
 rtl/shift_reg_sequencer.sv | 103 ++++++++++
 tb/tb_shift_reg_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_seq_pkg.sv
// Shared types and constants for the two-requester shift-register sequencer.
package shift_reg_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic GRANT_REQ0 = 1'b0;
  localparam logic GRANT_REQ1 = 1'b1;

endpackage

// File: rtl/shift_reg_core.sv
// Parallel-load, MSB-first shift register with zero fill; load wins over shift.
module shift_reg_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = parallel_in;
    end else if (shift_en) begin
      data_d = {data_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign parallel_out = data_q;

endmodule

// File: rtl/shift_reg_sequencer.sv
// Round-robin arbiter + FSM that loads a requester word and serializes it MSB-first.
module shift_reg_sequencer
  import shift_reg_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             serial_out,
  output logic             serial_valid,
  input  logic             serial_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             grant_id,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            grant_q, grant_d;
  logic            pick0, pick1;
  logic            load, shift_en;
  logic [WIDTH-1:0] load_data;

  // On a tie the requester that did not win last time is favoured.
  assign pick0 = req0_valid & (~req1_valid | (last_q == GRANT_REQ1));
  assign pick1 = req1_valid & ~pick0;

  assign req0_ready = (state_q == IDLE) & pick0;
  assign req1_ready = (state_q == IDLE) & pick1;

  assign load      = req0_ready | req1_ready;
  assign load_data = req1_ready ? req1_data : req0_data;
  assign shift_en  = (state_q == SHIFT) & serial_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          grant_d = req1_ready ? GRANT_REQ1 : GRANT_REQ0;
          last_d  = req1_ready ? GRANT_REQ1 : GRANT_REQ0;
          cnt_d   = CNT_LOAD;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (serial_ready) begin
          cnt_d = cnt_q - CNT_LAST;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= GRANT_REQ1;
      grant_q <= GRANT_REQ0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  shift_reg_core #(.WIDTH(WIDTH)) u_core (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .shift_en     (shift_en),
    .parallel_in  (load_data),
    .parallel_out (parallel_out)
  );

  assign serial_out   = parallel_out[WIDTH-1];
  assign serial_valid = (state_q == SHIFT);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign grant_id     = grant_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Scoreboard bench: stimulus pushes expected bits/grants, a monitor pops on each consumed bit and done.
module tb_shift_reg_sequencer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req0_valid = 1'b0;
  logic [WIDTH-1:0] req0_data = '0;
  logic             req0_ready;
  logic             req1_valid = 1'b0;
  logic [WIDTH-1:0] req1_data = '0;
  logic             req1_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             serial_ready = 1'b1;
  logic [WIDTH-1:0] parallel_out;
  logic             grant_id;
  logic             busy;
  logic             done;

  shift_reg_sequencer #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .serial_ready (serial_ready),
    .parallel_out (parallel_out),
    .grant_id     (grant_id),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic gid;
    logic b;
  } exp_t;

  exp_t bit_q[$];
  logic done_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic gid, input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) bit_q.push_back('{gid: gid, b: w[i]});
    done_q.push_back(gid);
  endtask

  function automatic logic [10:0] all_outs();
    return {serial_out, serial_valid, parallel_out, grant_id, busy, done, req0_ready, req1_ready};
  endfunction

  // Counts negedges until done is seen; -1 if the budget expires.
  task automatic wait_done(input int max, output int k);
    bit found = 0;
    k = 0;
    while (!found && k < max) begin
      @(negedge clk);
      k++;
      if (done) found = 1;
    end
    if (!found) k = -1;
  endtask

  task automatic wait_ready1(input int max, output int k);
    bit found = 0;
    k = 0;
    while (!found && k < max) begin
      @(negedge clk);
      k++;
      if (req1_ready) found = 1;
    end
    if (!found) k = -1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor: every consumed bit and every done pulse is matched against the scoreboard.
  initial begin
    exp_t e;
    logic g;
    forever begin
      @(negedge clk);
      if (!reset && serial_valid && serial_ready) begin
        if (bit_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_bit: got %0b expected none at %0t", serial_out, $time);
        end else begin
          e = bit_q.pop_front();
          check("serial_bit", 32'(serial_out), 32'(e.b));
          check("bit_grant", 32'(grant_id), 32'(e.gid));
        end
      end
      if (!reset && done) begin
        if (done_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: got 1 expected 0 at %0t", $time);
        end else begin
          g = done_q.pop_front();
          check("done_grant", 32'(grant_id), 32'(g));
          check("done_reg_zero", 32'(parallel_out), 32'(0));
          check("done_no_valid", 32'(serial_valid), 32'(0));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset with no requests: everything idle.
    #2;
    check("in_reset", 32'(all_outs()), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("idle_outputs", 32'(all_outs()), 32'(0));
    end

    // req0 sends 1010, sink always ready.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 4'b1010;
    @(negedge clk);
    check("t2_ready0", 32'(req0_ready), 32'(1));
    check("t2_ready1", 32'(req1_ready), 32'(0));
    push_word(1'b0, 4'b1010);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_done(20, k);
    check("t2_done_cycle", 32'(k), 32'(5));
    @(negedge clk);
    check("t2_busy_low", 32'(busy), 32'(0));

    // Tie from reset: req0 first, then req1 on the next IDLE.
    pulse_reset();
    req0_valid = 1'b1; req0_data = 4'b1100;
    req1_valid = 1'b1; req1_data = 4'b0111;
    @(negedge clk);
    check("t3_ready0", 32'(req0_ready), 32'(1));
    check("t3_ready1", 32'(req1_ready), 32'(0));
    push_word(1'b0, 4'b1100);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_ready1(20, k);
    check("t3_req1_grant_cycle", 32'(k), 32'(6));
    push_word(1'b1, 4'b0111);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_done(20, k);
    check("t3_done_cycle", 32'(k), 32'(5));
    check("t3_grant_id", 32'(grant_id), 32'(1));

    // Backpressure: sink stalls two cycles after the second bit.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 4'b1010;
    @(negedge clk);
    check("t4_ready0", 32'(req0_ready), 32'(1));
    push_word(1'b0, 4'b1010);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    serial_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t4_stall_bit", 32'(serial_out), 32'(1));
      check("t4_stall_valid", 32'(serial_valid), 32'(1));
      check("t4_stall_reg", 32'(parallel_out), 32'(4'b1000));
      @(posedge clk); #1;
    end
    serial_ready = 1'b1;
    wait_done(20, k);
    check("t4_done_delayed", 32'(k), 32'(3));

    // Asynchronous reset during the third bit of 1100.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 4'b1100;
    @(negedge clk);
    check("t5_ready0", 32'(req0_ready), 32'(1));
    push_word(1'b0, 4'b1100);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("t5_pre_reset_reg", 32'(parallel_out), 32'(4'b0000));
    bit_q.delete();
    done_q.delete();
    reset = 1'b1;
    #1;
    check("t5_async_reset", 32'(all_outs()), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    req1_valid = 1'b1; req1_data = 4'b0011;
    @(negedge clk);
    check("t5_ready1", 32'(req1_ready), 32'(1));
    push_word(1'b1, 4'b0011);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_done(20, k);
    check("t5_done_cycle", 32'(k), 32'(5));

    // req1 raised while req0's transaction is in flight waits for IDLE.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 4'b0110;
    @(negedge clk);
    check("t6_ready0", 32'(req0_ready), 32'(1));
    push_word(1'b0, 4'b0110);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 4'b1001;
    wait_ready1(20, k);
    check("t6_req1_grant_cycle", 32'(k), 32'(6));
    check("t6_idle_at_grant", 32'(busy), 32'(0));
    push_word(1'b1, 4'b1001);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_done(20, k);
    check("t6_done_cycle", 32'(k), 32'(5));

    @(negedge clk);
    check("bits_drained", 32'(bit_q.size()), 32'(0));
    check("dones_drained", 32'(done_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
